exibe_sequencia: RTL and testbench

- Plays the stored sequence back to the player, from address 0 to the current round limit, on the LEDs of the sequence game.
- Each item lights for T_ON cycles, then the LEDs go dark for T_OFF cycles.
- Sits between the sequence memory and the LED outputs. The unidade_controle starts it with a request/done handshake before handing control to the player's button input.

---
 rtl/exibe_sequencia_if.sv | 36 +++
 rtl/exibe_sequencia.sv | 136 +++++++++++++
 tb/tb_exibe_sequencia.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/exibe_sequencia_if.sv
// Bundle between the sequence player, the sequence memory and the LED outputs.
// EXIBE_SEQUENCIA_RGB_EN adds the conf_leds select and the rgb output.
interface exibe_sequencia_if;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       fim;
  logic [3:0] db_estado;
`ifdef EXIBE_SEQUENCIA_RGB_EN
  logic       conf_leds;
  logic [2:0] rgb;

  modport master (
    output iniciar, limite, dado_memoria, conf_leds,
    input  endereco, leds, ocupado, fim, db_estado, rgb
  );

  modport slave (
    input  iniciar, limite, dado_memoria, conf_leds,
    output endereco, leds, ocupado, fim, db_estado, rgb
  );
`else
  modport master (
    output iniciar, limite, dado_memoria,
    input  endereco, leds, ocupado, fim, db_estado
  );

  modport slave (
    input  iniciar, limite, dado_memoria,
    output endereco, leds, ocupado, fim, db_estado
  );
`endif
endinterface

// File: rtl/exibe_sequencia.sv
// Plays memory addresses 0..limite on the LEDs, T_ON lit then T_OFF dark per item.
// Defining EXIBE_SEQUENCIA_RGB_EN adds the rgb output and the conf_leds select.
module exibe_sequencia #(
  parameter int T_ON  = 1000,
  parameter int T_OFF = 500
) (
  input logic               clock,
  input logic               reset,
  exibe_sequencia_if.slave  bus
);

  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {
    REPOUSO = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    FIM     = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] timer;
  logic [3:0]    endereco;
  logic [3:0]    limite_reg;
  logic [3:0]    led_reg;
  logic          ton_done;
  logic          toff_done;
  logic          ultimo;

  assign ton_done  = (timer == TW'(T_ON - 1));
  assign toff_done = (timer == TW'(T_OFF - 1));
  assign ultimo    = (endereco == limite_reg);

  assign bus.endereco = endereco;
  assign bus.leds     = led_reg;

`ifdef EXIBE_SEQUENCIA_RGB_EN
  logic [2:0] rgb_reg;

  function automatic logic [2:0] cor(input logic [3:0] v);
    case (v)
      4'b0001: cor = 3'b100;
      4'b0010: cor = 3'b010;
      4'b0100: cor = 3'b001;
      4'b1000: cor = 3'b110;
      default: cor = 3'b000;
    endcase
  endfunction

  assign bus.rgb = rgb_reg;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= REPOUSO;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      REPOUSO: if (bus.iniciar) next_state = CARREGA;
      CARREGA: next_state = ACENDE;
      ACENDE:  if (ton_done) next_state = APAGA;
      APAGA:   if (toff_done) next_state = ultimo ? FIM : CARREGA;
      FIM:     next_state = REPOUSO;
      default: next_state = REPOUSO;
    endcase
  end

  // The LED register is loaded on entry to ACENDE and cleared on exit, so it is lit only there.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer      <= '0;
      endereco   <= '0;
      limite_reg <= '0;
      led_reg    <= '0;
`ifdef EXIBE_SEQUENCIA_RGB_EN
      rgb_reg    <= '0;
`endif
    end else begin
      case (state)
        REPOUSO: begin
          if (bus.iniciar) begin
            limite_reg <= bus.limite;
            endereco   <= '0;
            timer      <= '0;
          end
        end
        CARREGA: begin
          timer <= '0;
`ifdef EXIBE_SEQUENCIA_RGB_EN
          led_reg <= bus.conf_leds ? 4'b0000 : bus.dado_memoria;
          rgb_reg <= bus.conf_leds ? cor(bus.dado_memoria) : 3'b000;
`else
          led_reg <= bus.dado_memoria;
`endif
        end
        ACENDE: begin
          if (ton_done) begin
            timer   <= '0;
            led_reg <= '0;
`ifdef EXIBE_SEQUENCIA_RGB_EN
            rgb_reg <= '0;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end
        APAGA: begin
          if (toff_done) begin
            timer <= '0;
            if (!ultimo) endereco <= endereco + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ocupado   = 1'b0;
    bus.fim       = 1'b0;
    bus.db_estado = {1'b0, state};
    case (state)
      CARREGA, ACENDE, APAGA: bus.ocupado = 1'b1;
      FIM:                    bus.fim     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia with T_ON=4, T_OFF=2 (7-cycle item period).
module tb_exibe_sequencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int PER   = 1 + T_ON + T_OFF;

  typedef struct packed {
    logic [3:0] endereco;
    logic [3:0] leds;
    logic [3:0] db_estado;
    logic       ocupado;
    logic       fim;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] mem [16];
  int         vectors     = 0;
  int         miscompares = 0;

  always #5 clock = ~clock;

  exibe_sequencia_if bus ();

  assign bus.dado_memoria = mem[bus.endereco];

  exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Expected outputs k cycles after the edge that sampled iniciar, from item period arithmetic.
  function automatic obs_t model(input int k, input logic [3:0] lim);
    obs_t e;
    int   n;
    int   item;
    int   phase;
    e = '0;
    n = int'(lim) + 1;
    if (k <= n * PER) begin
      item       = (k - 1) / PER;
      phase      = (k - 1) % PER;
      e.endereco = item[3:0];
      e.ocupado  = 1'b1;
      if (phase == 0) begin
        e.db_estado = 4'd1;
      end else if (phase <= T_ON) begin
        e.db_estado = 4'd2;
        e.leds      = mem[item];
      end else begin
        e.db_estado = 4'd3;
      end
    end else if (k == n * PER + 1) begin
      e.endereco  = lim;
      e.fim       = 1'b1;
      e.db_estado = 4'd4;
    end else begin
      e.endereco = lim;
    end
    return e;
  endfunction

  task automatic compare(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_output(input string tag, input obs_t e);
    compare({tag, " endereco"},  bus.endereco,  e.endereco);
    compare({tag, " leds"},      bus.leds,      e.leds);
    compare({tag, " db_estado"}, bus.db_estado, e.db_estado);
    compare({tag, " ocupado"},   {3'b0, bus.ocupado}, {3'b0, e.ocupado});
    compare({tag, " fim"},       {3'b0, bus.fim},     {3'b0, e.fim});
  endtask

  task automatic randomize_memory();
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
  endtask

  // glitch_k: cycle at which iniciar is pulsed and limite changed; reset_k: cycle reset rises.
  task automatic apply_stimulus(input logic [3:0] lim, input int glitch_k, input int reset_k);
    int total;
    total = (int'(lim) + 1) * PER + 3;
    @(negedge clock);
    bus.iniciar = 1'b1;
    bus.limite  = lim;
    for (int k = 1; k <= total; k++) begin
      @(negedge clock);
      if (k == 1) bus.iniciar = 1'b0;
      if (reset_k > 0 && k == reset_k + 1) begin
        check_output($sformatf("lim%0d reset k%0d", lim, k), '0);
        reset = 1'b0;
        repeat (5) begin
          @(negedge clock);
          check_output($sformatf("lim%0d after reset", lim), '0);
        end
        return;
      end
      check_output($sformatf("lim%0d k%0d", lim, k), model(k, lim));
      if (k == glitch_k) begin
        bus.iniciar = 1'b1;
        bus.limite  = 4'd0;
      end
      if (k == glitch_k + 1) bus.iniciar = 1'b0;
      if (k == reset_k) reset = 1'b1;
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.iniciar = 1'b0;
    bus.limite  = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;

    $display("[TB] reset and idle");
    repeat (2) begin
      @(negedge clock);
      check_output("reset", '0);
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clock);
      check_output("idle", '0);
    end

    $display("[TB] single item");
    mem[0] = 4'b0100;
    apply_stimulus(4'd0, -1, -1);

    $display("[TB] four items");
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    mem[3] = 4'b1000;
    apply_stimulus(4'd3, -1, -1);

    $display("[TB] ignored iniciar and limite during playback");
    apply_stimulus(4'd3, 10, -1);

    $display("[TB] reset mid-playback");
    apply_stimulus(4'd3, -1, 12);

    $display("[TB] full limite");
    randomize_memory();
    apply_stimulus(4'd15, -1, -1);

    $display("[TB] random runs");
    for (int r = 0; r < 3; r++) begin
      randomize_memory();
      repeat ($urandom_range(0, 3)) @(negedge clock);
      apply_stimulus(4'($urandom_range(0, 15)), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
